// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_MW = DEFAULT_DW / 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner pick for the arbiter; MEM_ARB_RR_EN selects round-robin
// tie-breaking, otherwise the LSU wins every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  output logic pick
);

  always_comb begin
    pick = MID_IFU;
    if (if_valid && ls_valid) begin
`ifdef MEM_ARB_RR_EN
      // Tie goes to whichever master was not granted most recently.
      pick = (last == MID_LSU) ? MID_IFU : MID_LSU;
`else
      pick = MID_LSU;
`endif
    end else if (ls_valid) begin
      pick = MID_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) single-port memory arbiter with one outstanding transaction.
// Build option: MEM_ARB_RR_EN enables round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_valid,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ready,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_rerr,

  input  logic            ls_valid,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_ready,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_rerr,

  output logic            m_valid,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rerr,

  output logic            busy
);

  arb_state_t state;
  logic       owner;
  logic       pick;
  logic       any_valid;
  logic       grant;
  logic       req_fire;
  logic       rsp_fire;

  assign any_valid = if_valid | ls_valid;
  assign grant     = (state == IDLE) && any_valid;
  assign req_fire  = (state == REQ) && m_ready;
  assign rsp_fire  = (state == RSP) && m_rvalid;

`ifdef MEM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= MID_IFU;
    end else if (grant) begin
      last <= pick;
    end
  end

  mem_arb_pick u_pick (
    .if_valid (if_valid),
    .ls_valid (ls_valid),
    .last     (last),
    .pick     (pick)
  );
`else
  mem_arb_pick u_pick (
    .if_valid (if_valid),
    .ls_valid (ls_valid),
    .pick     (pick)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= MID_IFU;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= pick;
            state <= REQ;
          end
        end
        REQ: begin
          // A response in the accept cycle is ignored; it must come later.
          if (m_ready) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (m_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are forwarded live from the owner; nothing is latched.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_wdata = '0;
    m_wmask = '0;
    if (state == REQ) begin
      m_valid = 1'b1;
      if (owner == MID_LSU) begin
        m_addr  = ls_addr;
        m_wen   = ls_wen;
        m_wdata = ls_wdata;
        m_wmask = ls_wmask;
      end else begin
        m_addr  = if_addr;
      end
    end
  end

  always_comb begin
    if_ready  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_rerr   = 1'b0;
    ls_ready  = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    ls_rerr   = 1'b0;
    if (owner == MID_LSU) begin
      ls_ready = req_fire;
      if (rsp_fire) begin
        ls_rvalid = 1'b1;
        ls_rdata  = m_rdata;
        ls_rerr   = m_rerr;
      end
    end else begin
      if_ready = req_fire;
      if (rsp_fire) begin
        if_rvalid = 1'b1;
        if_rdata  = m_rdata;
        if_rerr   = m_rerr;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-port memory arbiter that shares one downstream memory interface between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core. It grants one master at a time and forwards that master's request unchanged. It tracks the single outstanding transaction and routes the response back to its owner. It sits between the IFU/LSU request ports and the memory/bus bridge, under the core's fetch/execute sequencing controller.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; write-mask width is `DW/8`.

Ports:
- `clk` in 1: clock. One clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_valid` in 1: IFU request; held until `if_ready`.
- `if_addr` in AW: IFU read address.
- `if_ready` out 1: IFU request accepted downstream.
- `if_rvalid` out 1: IFU response, one-cycle pulse.
- `if_rdata` out DW: IFU read data, valid with `if_rvalid`.
- `if_rerr` out 1: IFU access fault, valid with `if_rvalid`.
- `ls_valid` in 1: LSU request; held until `ls_ready`.
- `ls_addr` in AW: LSU address.
- `ls_wen` in 1: LSU write enable.
- `ls_wdata` in DW: LSU write data.
- `ls_wmask` in DW/8: LSU byte mask.
- `ls_ready`, `ls_rvalid`, `ls_rdata`, `ls_rerr`: as the IFU equivalents, for the LSU.
- `m_valid` out 1, `m_addr` out AW, `m_wen` out 1, `m_wdata` out DW, `m_wmask` out DW/8: downstream request.
- `m_ready` in 1: downstream accepts the request.
- `m_rvalid` in 1, `m_rdata` in DW, `m_rerr` in 1: downstream response.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: with no request pending, stay in IDLE. With any `*_valid` high, register `owner` from the arbitration pick and go to REQ.
  - REQ: `m_valid`=1; request fields are muxed from `owner`; IFU requests drive `m_wen`=0, `m_wdata`=0 and `m_wmask`=0. When `m_ready`=1, pulse `owner`'s `*_ready` in the same cycle and go to RSP.
  - RSP: when `m_rvalid`=1, drive `owner`'s `*_rvalid`, `*_rdata` and `*_rerr` combinationally in the same cycle, then go to IDLE.
- Only one transaction is outstanding at a time. A new grant can only be made from IDLE.
- The non-owner's `*_ready` and `*_rvalid` are always 0. Its `*_rdata` is 0.
- In IDLE and REQ, `m_rvalid` is ignored and `m_rdata` is dropped.
- Masters must hold their request fields stable while `*_valid` is high. The arbiter does not latch addresses or data.
- A request whose `*_valid` drops before its grant is withdrawn: it is not tracked and no response is generated.
- A master deasserting `*_valid` while in REQ is a protocol violation; the behaviour is undefined.

## Timing
- Reset value of every output is 0. `owner` resets to IFU, state resets to IDLE, `last` resets to IFU.
- Minimum latency from `*_valid` to `m_valid` is 1 cycle (the IDLE→REQ register).
- `*_ready` follows `m_ready` in the same cycle. `*_rvalid` follows `m_rvalid` in the same cycle.
- Back-to-back transactions: RSP→IDLE→REQ, so there is at least one idle cycle between the response and the next `m_valid`.
- Reset asserted mid-REQ or mid-RSP: return to IDLE immediately and drop all outputs to 0. A downstream response arriving after reset is discarded (IDLE ignores `m_rvalid`).
- `m_ready` and `m_rvalid` in the same cycle while in REQ: accept the request only and go to RSP. The response must arrive later.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On simultaneous `if_valid` and `ls_valid`, grant the master that is not `last`. `last` updates to `owner` on each grant. After reset the first tie goes to the LSU.
- `MEM_ARB_RR_EN` undefined: fixed priority, LSU always wins ties, and the `last` register is not generated.
- A single requester is always granted regardless of configuration.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum `{IDLE, REQ, RSP}`;
  - master-ID constants `MID_IFU`=0, `MID_LSU`=1;
  - width localparams derived from `AW` and `DW`.
- Sub-module `mem_arb_pick`: combinational pick of `owner` from the two valids plus `last`. It contains the `MEM_ARB_RR_EN` conditional, so the arbiter FSM is identical in both builds.

## Test plan
- IFU only: `if_addr`=0x80000000, `m_ready` given 2 cycles after `m_valid`, `m_rvalid` with `m_rdata`=0x00100093 three cycles later → `m_valid` rises 1 cycle after `if_valid`; a single `if_ready` pulse; `if_rvalid` carries 0x00100093 with `if_rerr`=0; `ls_*` outputs stay 0.
- LSU store: `ls_addr`=0x80001000, `ls_wen`=1, `ls_wdata`=0xDEADBEEF, `ls_wmask`=0xF → these values appear unchanged on `m_*`; `ls_rvalid` pulses once.
- Tie, fixed priority (macro undefined): both valid in the same cycle for 3 consecutive transactions → the LSU is granted first every time; the IFU is granted only after `ls_valid` drops.
- Tie, round-robin (macro defined): both valid continuously for 4 transactions → grant order is LSU, IFU, LSU, IFU.
- Reset mid-RSP: assert `rst` while in RSP, then drive `m_rvalid`=1 after release → all outputs are 0, neither master gets `*_rvalid`, and `busy` is 0.
- Fault passthrough: IFU read with `m_rerr`=1 → `if_rvalid`=1 and `if_rerr`=1 in the same cycle; the FSM returns to IDLE.
